s_block_writer: RTL and testbench

- Downstream stage of the IDCT matrix multiplier.
- After the multiplier finishes the S pass, this block reads the 8x8 S block from the S dual-port RAM and clips each 32-bit signed entry to an unsigned 8-bit pixel.
- It packs two horizontally adjacent pixels per 16-bit word and writes the 32 words to external SRAM at the block's position in the frame.
- The top-level milestone FSM starts it, then waits for WS_done before launching the next block.

---
 rtl/s_block_writer.sv | 170 +++++++++++++++++
 tb/tb_s_block_writer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_block_writer.sv
// s_block_writer: drains one 8x8 S block from the S dual-port RAM, clips
// each signed entry to an 8-bit pixel, packs horizontal pixel pairs into
// 16-bit words and writes the 32 words to SRAM at the block's frame position.
module s_block_writer #(
    parameter logic [17:0] BASE_ADDR     = 18'd0,
    parameter int          WORDS_PER_ROW = 160,
    parameter int          DATA_W        = 32
) (
    input  logic              CLOCK_50_I,
    input  logic              Resetn,
    input  logic              WS_start,
    output logic              WS_done,
    input  logic [4:0]        block_row,
    input  logic [5:0]        block_col,
    output logic [6:0]        S_read_address,
    input  logic [DATA_W-1:0] S_read_data,
    output logic [17:0]       SRAM_address,
    output logic [15:0]       SRAM_write_data,
    output logic              SRAM_we_n
);

    typedef enum logic [1:0] {
        S_WS_IDLE,
        S_WS_LI,
        S_WS_CC,
        S_WS_LO
    } ws_state_t;

    ws_state_t   state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic [5:0]  rd_addr_q, rd_addr_d;
    logic        vld_p0_q, vld_p0_d;
    logic        vld_p1_q, vld_p1_d;
    logic [5:0]  samp_idx_q, samp_idx_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [17:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        we_n_q, we_n_d;
    logic        done_q, done_d;

    // Saturate a signed S entry into the 0..255 pixel range.
    function automatic logic [7:0] clip_pixel(input logic signed [DATA_W-1:0] v);
        if (v[DATA_W-1]) begin
            return 8'd0;
        end else if (|v[DATA_W-2:8]) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

    // SRAM word address of packed word j (row j/4, word-in-row j%4) of the
    // latched block; wraps modulo 2^18 with no range check.
    function automatic logic [17:0] word_addr(input logic [4:0] row,
                                              input logic [5:0] col,
                                              input logic [4:0] j);
        logic [17:0] line;
        line = (18'(row) << 3) + 18'(j[4:2]);
        return BASE_ADDR + line * 18'(WORDS_PER_ROW) + (18'(col) << 2) + 18'(j[1:0]);
    endfunction

    // Next-state, read-address sequencing and the clip/pack datapath.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        rd_addr_d  = rd_addr_q;
        vld_p0_d   = vld_p0_q;
        samp_idx_d = samp_idx_q;
        hi_byte_d  = hi_byte_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        we_n_d     = 1'b1;
        done_d     = 1'b0;

        // p0 -> p1: the RAM registers the address, so its data follows one cycle later
        vld_p1_d = vld_p0_q;

        case (state_q)
            S_WS_IDLE: begin
                rd_addr_d = 6'd0;
                vld_p0_d  = 1'b0;
                if (WS_start) begin
                    state_d    = S_WS_LI;
                    row_d      = block_row;
                    col_d      = block_col;
                    vld_p0_d   = 1'b1;
                    samp_idx_d = 6'd0;
                end
            end
            S_WS_LI, S_WS_CC: begin
                if (state_q == S_WS_LI) begin
                    state_d = S_WS_CC;
                end
                // Address stream runs 0..63 and then parks on 63.
                if (rd_addr_q != 6'd63) begin
                    rd_addr_d = rd_addr_q + 6'd1;
                    vld_p0_d  = 1'b1;
                end else begin
                    vld_p0_d  = 1'b0;
                end
                if (state_q == S_WS_CC && vld_p1_q && samp_idx_q == 6'd63) begin
                    state_d = S_WS_LO;
                end
            end
            S_WS_LO: begin
                state_d  = S_WS_IDLE;
                vld_p0_d = 1'b0;
                done_d   = 1'b1;
            end
            default: begin
                state_d = S_WS_IDLE;
            end
        endcase

        // p1 -> p2: even entries park in the high byte, odd entries complete a word
        if (vld_p1_q) begin
            samp_idx_d = samp_idx_q + 6'd1;
            if (!samp_idx_q[0]) begin
                hi_byte_d = clip_pixel(S_read_data);
            end else begin
                wr_data_d = {hi_byte_q, clip_pixel(S_read_data)};
                wr_addr_d = word_addr(row_q, col_q, samp_idx_q[5:1]);
                we_n_d    = 1'b0;
            end
        end
    end

    // Control state and registered outputs; reset aborts any block in flight.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_WS_IDLE;
            row_q      <= 5'd0;
            col_q      <= 6'd0;
            rd_addr_q  <= 6'd0;
            vld_p0_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            samp_idx_q <= 6'd0;
            wr_addr_q  <= 18'd0;
            wr_data_q  <= 16'd0;
            we_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rd_addr_q  <= rd_addr_d;
            vld_p0_q   <= vld_p0_d;
            vld_p1_q   <= vld_p1_d;
            samp_idx_q <= samp_idx_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            we_n_q     <= we_n_d;
            done_q     <= done_d;
        end
    end

    // High-byte holding register; always written before it is consumed.
    always_ff @(posedge CLOCK_50_I) begin
        hi_byte_q <= hi_byte_d;
    end

    assign WS_done         = done_q;
    assign S_read_address  = {1'b0, rd_addr_q};
    assign SRAM_address    = wr_addr_q;
    assign SRAM_write_data = wr_data_q;
    assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_s_block_writer.sv
// Bench for s_block_writer: random S blocks, scoreboard of expected SRAM
// writes built from a plain arithmetic model, plus timing/reset checks.
module tb_s_block_writer;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        WS_start;
    logic [4:0]  block_row;
    logic [5:0]  block_col;
    logic [31:0] S_read_data;
    logic        WS_done, WS_done2;
    logic [6:0]  S_read_address, S_read_address2;
    logic [17:0] SRAM_address, SRAM_address2;
    logic [15:0] SRAM_write_data, SRAM_write_data2;
    logic        SRAM_we_n, SRAM_we_n2;

    logic [31:0] s_mem [64];
    wr_t         q0[$];
    wr_t         q1[$];
    logic        sb_ignore;
    int          errors = 0;
    int          checks = 0;

    logic [17:0] cap_addr  [32];
    logic [17:0] cap_addr2 [32];
    logic [15:0] cap_data  [32];

    s_block_writer dut (
        .CLOCK_50_I(clk), .Resetn(Resetn), .WS_start(WS_start), .WS_done(WS_done),
        .block_row(block_row), .block_col(block_col),
        .S_read_address(S_read_address), .S_read_data(S_read_data),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n)
    );

    s_block_writer #(.BASE_ADDR(18'd38400)) dut2 (
        .CLOCK_50_I(clk), .Resetn(Resetn), .WS_start(WS_start), .WS_done(WS_done2),
        .block_row(block_row), .block_col(block_col),
        .S_read_address(S_read_address2), .S_read_data(S_read_data),
        .SRAM_address(SRAM_address2), .SRAM_write_data(SRAM_write_data2),
        .SRAM_we_n(SRAM_we_n2)
    );

    always #10 clk = ~clk;

    // S RAM model: registered read, one cycle latency.
    always @(posedge clk) S_read_data <= s_mem[S_read_address[5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] clip8(input logic [31:0] v);
        int sv;
        sv = int'(signed'(v));
        if (sv < 0) return 8'd0;
        if (sv > 255) return 8'd255;
        return 8'(sv);
    endfunction

    function automatic logic [17:0] model_addr(input int base, input int row, input int col, input int j);
        int line;
        line = row * 8 + j / 4;
        return 18'((base + line * 160 + col * 4 + j % 4) % 262144);
    endfunction

    // Expected 32 writes for a block at (row,col) with the current S contents.
    task automatic push_block(input int row, input int col);
        wr_t e;
        for (int j = 0; j < 32; j++) begin
            e.data = {clip8(s_mem[2*j]), clip8(s_mem[2*j+1])};
            e.addr = model_addr(0, row, col, j);
            q0.push_back(e);
            e.addr = model_addr(38400, row, col, j);
            q1.push_back(e);
        end
    endtask

    function automatic logic [31:0] rand_s();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255));
            1:       return -32'($urandom_range(1, 1000));
            2:       return 32'(256 + $urandom_range(0, 1000));
            default: return $urandom();
        endcase
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 64; k++) s_mem[k] = rand_s();
    endtask

    // Scoreboard monitor for the BASE_ADDR=0 instance.
    always @(negedge clk) begin
        wr_t e;
        if (!SRAM_we_n && !sb_ignore) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write dut: addr=%0d data=%h, none expected", SRAM_address, SRAM_write_data);
            end else begin
                e = q0.pop_front();
                chk("wr_addr", 32'(SRAM_address), 32'(e.addr));
                chk("wr_data", 32'(SRAM_write_data), 32'(e.data));
            end
        end
    end

    // Scoreboard monitor for the BASE_ADDR=38400 instance.
    always @(negedge clk) begin
        wr_t e;
        if (!SRAM_we_n2 && !sb_ignore) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write dut2: addr=%0d data=%h, none expected", SRAM_address2, SRAM_write_data2);
            end else begin
                e = q1.pop_front();
                chk("wr_addr2", 32'(SRAM_address2), 32'(e.addr));
                chk("wr_data2", 32'(SRAM_write_data2), 32'(e.data));
            end
        end
    end

    // One block: start, optional mid-block start pulse / input scrambling,
    // timing checks on the strobe pattern and done pulse. Entered and left on a negedge.
    task automatic run_block(input int row, input int col, input bit hold,
                             input bit mid_pulse, input bit mix_inputs);
        int done_n;
        int wr;
        block_row = 5'(row);
        block_col = 6'(col);
        push_block(row, col);
        WS_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) WS_start = 1'b0;
        if (mix_inputs) begin
            block_row = 5'($urandom);
            block_col = 6'($urandom);
        end
        done_n = -1;
        wr = 0;
        for (int n = 1; n <= 100 && done_n < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mid_pulse && n == 19) WS_start = 1'b1;
            if (mid_pulse && n == 20) WS_start = 1'b0;
            if (!SRAM_we_n) begin
                if (wr < 32) begin
                    cap_addr[wr]  = SRAM_address;
                    cap_addr2[wr] = SRAM_address2;
                    cap_data[wr]  = SRAM_write_data;
                end
                wr++;
            end
            if (n == 1)  chk("rd_addr_e1", 32'(S_read_address), 32'd1);
            if (n == 1)  chk("rd_addr2_e1", 32'(S_read_address2), 32'd1);
            if (n == 2)  chk("we_idle_e2", 32'(SRAM_we_n), 32'd1);
            if (n == 3)  chk("we_first_e3", 32'(SRAM_we_n), 32'd0);
            if (n == 4)  chk("we_gap_e4", 32'(SRAM_we_n), 32'd1);
            if (n == 64) chk("rd_addr_hold", 32'(S_read_address), 32'd63);
            if (n == 66) chk("dut2_done", 32'(WS_done2), 32'd1);
            if (WS_done) done_n = n;
        end
        chk("done_latency", 32'(done_n), 32'd66);
        chk("write_count", 32'(wr), 32'd32);
        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_pulse_width", 32'(WS_done), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn    = 1'b0;
        WS_start  = 1'b0;
        block_row = 5'd0;
        block_col = 6'd0;
        sb_ignore = 1'b0;
        for (int k = 0; k < 64; k++) s_mem[k] = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(WS_done), 32'd0);
        chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst_rd_addr", 32'(S_read_address), 32'd0);
        chk("rst_sram_addr", 32'(SRAM_address), 32'd0);
        chk("rst_sram_data", 32'(SRAM_write_data), 32'd0);
        chk("rst_sram_addr2", 32'(SRAM_address2), 32'd0);
        Resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Block (0,0) with S[k] = 4k
        for (int k = 0; k < 64; k++) s_mem[k] = 32'(k * 4);
        run_block(0, 0, 1'b0, 1'b0, 1'b0);
        chk("b00_w0_addr", 32'(cap_addr[0]), 32'd0);
        chk("b00_w0_data", 32'(cap_data[0]), 32'h0004);
        chk("b00_w4_addr", 32'(cap_addr[4]), 32'd160);
        chk("b00_w4_data", 32'(cap_data[4]), 32'h2024);

        // Clipping corners
        fill_random();
        s_mem[0] = -32'd5;
        s_mem[1] = 32'd256;
        s_mem[2] = 32'd255;
        s_mem[3] = 32'd0;
        s_mem[4] = 32'h7FFF_FFFF;
        s_mem[5] = 32'h8000_0000;
        run_block(2, 3, 1'b0, 1'b0, 1'b0);
        chk("clip_w0", 32'(cap_data[0]), 32'h00FF);
        chk("clip_w1", 32'(cap_data[1]), 32'hFF00);
        chk("clip_w2", 32'(cap_data[2]), 32'hFF00);

        // Last block of the frame, both base addresses
        fill_random();
        run_block(29, 39, 1'b0, 1'b0, 1'b0);
        chk("b2939_first", 32'(cap_addr[0]), 32'd37276);
        chk("b2939_last", 32'(cap_addr[31]), 32'd38399);
        chk("b2939_first_base", 32'(cap_addr2[0]), 32'd75676);
        chk("b2939_last_base", 32'(cap_addr2[31]), 32'd76799);

        // Start pulse mid-block and input changes after acceptance are ignored
        fill_random();
        run_block(7, 11, 1'b0, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        chk("idle_after_ignored_start", 32'(SRAM_we_n), 32'd1);

        // Abort by reset mid-block, then no writes without a start
        sb_ignore = 1'b1;
        fill_random();
        block_row = 5'd3;
        block_col = 6'd5;
        WS_start = 1'b1;
        @(posedge clk);
        #1;
        WS_start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("abort_we_low_before", 32'(SRAM_we_n), 32'd0);
        #1;
        Resetn = 1'b0;
        #1;
        chk("abort_we_n", 32'(SRAM_we_n), 32'd1);
        chk("abort_done", 32'(WS_done), 32'd0);
        chk("abort_rd_addr", 32'(S_read_address), 32'd0);
        chk("abort_sram_addr", 32'(SRAM_address), 32'd0);
        chk("abort_sram_data", 32'(SRAM_write_data), 32'd0);
        repeat (3) @(negedge clk);
        sb_ignore = 1'b0;
        Resetn = 1'b1;
        repeat (10) @(negedge clk);
        fill_random();
        run_block(5, 6, 1'b0, 1'b0, 1'b0);

        // Back-to-back with WS_start held high
        for (int b = 0; b < 4; b++) begin
            fill_random();
            run_block($urandom_range(0, 31), $urandom_range(0, 63), (b != 3), 1'b0, 1'b0);
        end

        // Random blocks with random idle gaps
        for (int b = 0; b < 6; b++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fill_random();
            run_block($urandom_range(0, 31), $urandom_range(0, 63), 1'b0, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("queue0_empty", 32'(q0.size()), 32'd0);
        chk("queue1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
